// File: rtl/fifo_to_ram_drain.sv
// rtl/fifo_to_ram_drain.sv - drains a dcfifo read port into a single-port RAM, one word per transaction
module fifo_to_ram_drain #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int FIFO_LATENCY = 1,
    parameter int WRAP_EN      = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              rdempty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              rdreq_o,
    output logic              wren_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              ram_full_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [1:0] LAT_LOAD = (FIFO_LATENCY > 0) ? 2'(FIFO_LATENCY - 1) : 2'd0;

    typedef enum logic [2:0] {IDLE, READ, LAT, WRITE, WAIT, FULL} state_t;

    state_t            state, state_n;
    logic [1:0]        lat_cnt, lat_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [ADDR_W:0]   count_n;
    logic              full_n;
    logic              done_n;
    logic              start_read;

    assign start_read = enable_i && !rdempty_i;
    assign rdreq_o    = (state == READ);
    assign wren_o     = (state == WRITE);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            to_cnt       <= '0;
            addr_o       <= '1;
            wdata_o      <= '0;
            word_count_o <= '0;
            ram_full_o   <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_n;
            lat_cnt      <= lat_cnt_n;
            to_cnt       <= to_cnt_n;
            addr_o       <= addr_n;
            wdata_o      <= wdata_n;
            word_count_o <= count_n;
            ram_full_o   <= full_n;
            done_o       <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        lat_cnt_n = lat_cnt;
        to_cnt_n  = to_cnt;
        addr_n    = addr_o;
        wdata_n   = wdata_o;
        count_n   = word_count_o;
        full_n    = ram_full_o;
        done_n    = 1'b0;

        // clear drops any requested-but-unwritten word; wdata keeps its last value
        if (clear_i) begin
            state_n   = IDLE;
            lat_cnt_n = '0;
            to_cnt_n  = '0;
            addr_n    = '1;
            count_n   = '0;
            full_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_read) begin
                        state_n = READ;
                        addr_n  = addr_o + 1'b1;
                        count_n = '0;
                    end
                end
                READ: begin
                    if (FIFO_LATENCY == 0) begin
                        wdata_n = fifo_data_i;
                        state_n = WRITE;
                    end else begin
                        lat_cnt_n = LAT_LOAD;
                        state_n   = LAT;
                    end
                end
                LAT: begin
                    if (lat_cnt == 2'd0) begin
                        wdata_n = fifo_data_i;
                        state_n = WRITE;
                    end else begin
                        lat_cnt_n = lat_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    count_n = word_count_o + 1'b1;
                    if (WRAP_EN == 0 && addr_o == '1) begin
                        state_n = FULL;
                        full_n  = 1'b1;
                    end else if (start_read) begin
                        state_n = READ;
                        addr_n  = addr_o + 1'b1;
                    end else begin
                        state_n  = WAIT;
                        to_cnt_n = '0;
                    end
                end
                WAIT: begin
                    if (start_read) begin
                        state_n  = READ;
                        addr_n   = addr_o + 1'b1;
                        to_cnt_n = '0;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                        if (to_cnt_n == TO_W'(IDLE_TIMEOUT)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            addr_n  = '1;
                        end
                    end
                end
                FULL: begin
                    state_n = FULL;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_to_ram_drain.sv
// tb/tb_fifo_to_ram_drain.sv - directed bench for fifo_to_ram_drain at three FIFO latencies
module tb_fifo_to_ram_drain;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int TO = 4;
    localparam int NI = 3;
    localparam int LAT  [NI] = '{1, 0, 2};
    localparam int BASE [NI] = '{'hA000, 'hB000, 'hC000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [NI][64];
    logic [5:0]    wr_ptr [NI] = '{6'd0, 6'd0, 6'd0};
    logic [5:0]    rd_ptr [NI] = '{6'd0, 6'd0, 6'd0};
    logic [DW-1:0] pipe1 [NI];
    logic [DW-1:0] pipe2 [NI];
    logic          rdempty [NI];
    logic [DW-1:0] fdata [NI];

    logic          rdreq [NI];
    logic          wren [NI];
    logic          full [NI];
    logic          busy [NI];
    logic          done [NI];
    logic [AW-1:0] addr [NI];
    logic [DW-1:0] wdata [NI];
    logic [AW:0]   wcount [NI];

    fifo_to_ram_drain #(.DATA_W(DW), .ADDR_W(AW), .FIFO_LATENCY(1), .WRAP_EN(0), .IDLE_TIMEOUT(TO)) u_a (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .enable_i(enable),
        .rdempty_i(rdempty[0]), .fifo_data_i(fdata[0]), .rdreq_o(rdreq[0]), .wren_o(wren[0]),
        .addr_o(addr[0]), .wdata_o(wdata[0]), .word_count_o(wcount[0]),
        .ram_full_o(full[0]), .busy_o(busy[0]), .done_o(done[0]));

    fifo_to_ram_drain #(.DATA_W(DW), .ADDR_W(AW), .FIFO_LATENCY(0), .WRAP_EN(1), .IDLE_TIMEOUT(TO)) u_b (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .enable_i(enable),
        .rdempty_i(rdempty[1]), .fifo_data_i(fdata[1]), .rdreq_o(rdreq[1]), .wren_o(wren[1]),
        .addr_o(addr[1]), .wdata_o(wdata[1]), .word_count_o(wcount[1]),
        .ram_full_o(full[1]), .busy_o(busy[1]), .done_o(done[1]));

    fifo_to_ram_drain #(.DATA_W(DW), .ADDR_W(AW), .FIFO_LATENCY(2), .WRAP_EN(1), .IDLE_TIMEOUT(TO)) u_c (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .enable_i(enable),
        .rdempty_i(rdempty[2]), .fifo_data_i(fdata[2]), .rdreq_o(rdreq[2]), .wren_o(wren[2]),
        .addr_o(addr[2]), .wdata_o(wdata[2]), .word_count_o(wcount[2]),
        .ram_full_o(full[2]), .busy_o(busy[2]), .done_o(done[2]));

    // FIFO read side: latency 0 shows the head word, otherwise it trails rdreq by LAT cycles
    always_comb begin
        for (int k = 0; k < NI; k++) begin
            rdempty[k] = (rd_ptr[k] == wr_ptr[k]);
            if (LAT[k] == 0)      fdata[k] = mem[k][rd_ptr[k]];
            else if (LAT[k] == 1) fdata[k] = pipe1[k];
            else                  fdata[k] = pipe2[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rdreq[k]) begin
                pipe1[k]  <= mem[k][rd_ptr[k]];
                rd_ptr[k] <= rd_ptr[k] + 6'd1;
            end
            pipe2[k] <= pipe1[k];
        end
    end

    int            cyc = 0;
    int            nw [NI] = '{0, 0, 0};
    int            nrd [NI] = '{0, 0, 0};
    int            ndone [NI] = '{0, 0, 0};
    logic [AW-1:0] laddr [NI][32];
    logic [DW-1:0] ldata [NI][32];
    int            lcyc [NI][32];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            if (wren[k] && nw[k] < 32) begin
                laddr[k][nw[k]] = addr[k];
                ldata[k][nw[k]] = wdata[k];
                lcyc[k][nw[k]]  = cyc;
                nw[k] = nw[k] + 1;
            end
            if (rdreq[k]) nrd[k] = nrd[k] + 1;
            if (done[k])  ndone[k] = ndone[k] + 1;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int k, input int d);
        mem[k][wr_ptr[k]] = DW'(d);
        wr_ptr[k] = wr_ptr[k] + 6'd1;
    endtask

    int b0, b1, b2, r0, d0;

    initial begin
        tick();
        tick();
        chk("rst_addr", addr[0], 7);
        chk("rst_wdata", wdata[0], 0);
        chk("rst_count", wcount[0], 0);
        chk("rst_full", full[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_rdreq", rdreq[0], 0);
        chk("rst_wren", wren[0], 0);
        chk("rst_addr_b", addr[1], 7);
        chk("rst_addr_c", addr[2], 7);
        reset = 1'b0;
        tick();

        // four words through each latency, then idle timeout
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 4; i++) push(k, BASE[k] + i);
        enable = 1'b1;
        for (int i = 0; i < 200 && !(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0); i++) tick();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("s1_nw%0d", k), nw[k], 4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("s1_addr%0d_%0d", k, i), laddr[k][i], i);
                chk($sformatf("s1_data%0d_%0d", k, i), ldata[k][i], BASE[k] + i);
            end
            chk($sformatf("s1_gap%0d", k), lcyc[k][3] - lcyc[k][0], 3 * (LAT[k] + 2));
            chk($sformatf("s1_count%0d", k), wcount[k], 4);
            chk($sformatf("s1_addr_end%0d", k), addr[k], 7);
            chk($sformatf("s1_ndone%0d", k), ndone[k], 1);
        end

        // ten words: A stops full, B and C wrap
        b0 = nw[0]; b1 = nw[1]; b2 = nw[2]; r0 = nrd[0];
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 10; i++) push(k, BASE[k] + 'h100 + i);
        for (int i = 0; i < 300 && !(ndone[1] > 1 && ndone[2] > 1 && full[0]); i++) tick();
        chk("s2_a_nw", nw[0] - b0, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s2_a_addr%0d", i), laddr[0][b0 + i], i);
            chk($sformatf("s2_a_data%0d", i), ldata[0][b0 + i], 'hA100 + i);
        end
        chk("s2_a_full", full[0], 1);
        chk("s2_a_busy", busy[0], 1);
        chk("s2_a_count", wcount[0], 8);
        chk("s2_a_nrd", nrd[0] - r0, 8);
        chk("s2_a_left", 32'(wr_ptr[0] - rd_ptr[0]), 2);
        chk("s2_a_ndone", ndone[0], 1);
        chk("s2_b_nw", nw[1] - b1, 10);
        chk("s2_c_nw", nw[2] - b2, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s2_b_addr%0d", i), laddr[1][b1 + i], i & 7);
            chk($sformatf("s2_c_addr%0d", i), laddr[2][b2 + i], i & 7);
            chk($sformatf("s2_c_data%0d", i), ldata[2][b2 + i], 'hC100 + i);
        end
        chk("s2_b_count", wcount[1], 10);
        chk("s2_c_count", wcount[2], 10);
        chk("s2_b_full", full[1], 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("s2_clr_full", full[0], 0);
        chk("s2_clr_addr", addr[0], 7);
        chk("s2_clr_count", wcount[0], 0);
        chk("s2_clr_busy", busy[0], 0);
        b0 = nw[0];
        for (int i = 0; i < 100 && ndone[0] < 2; i++) tick();
        chk("s2_rest_nw", nw[0] - b0, 2);
        chk("s2_rest_addr0", laddr[0][b0], 0);
        chk("s2_rest_data0", ldata[0][b0], 'hA108);
        chk("s2_rest_addr1", laddr[0][b0 + 1], 1);
        chk("s2_rest_data1", ldata[0][b0 + 1], 'hA109);
        chk("s2_rest_count", wcount[0], 2);

        // short gap in WAIT does not end the session
        b0 = nw[0]; d0 = ndone[0];
        for (int i = 0; i < 3; i++) push(0, 'hA200 + i);
        for (int i = 0; i < 50 && nw[0] - b0 < 3; i++) tick();
        tick();
        tick();
        chk("s3_no_done_gap", ndone[0], d0);
        push(0, 'hA203);
        push(0, 'hA204);
        for (int i = 0; i < 100 && ndone[0] == d0; i++) tick();
        chk("s3_ndone", ndone[0], d0 + 1);
        chk("s3_nw", nw[0] - b0, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s3_addr%0d", i), laddr[0][b0 + i], i);
            chk($sformatf("s3_data%0d", i), ldata[0][b0 + i], 'hA200 + i);
        end
        chk("s3_count", wcount[0], 5);
        chk("s3_addr_end", addr[0], 7);

        // enable dropped during LAT: word completes, no further read, timeout while disabled
        b0 = nw[0]; r0 = nrd[0]; d0 = ndone[0];
        push(0, 'hA300);
        push(0, 'hA301);
        for (int i = 0; i < 20 && !rdreq[0]; i++) tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10 && nw[0] - b0 < 1; i++) tick();
        for (int i = 0; i < 8; i++) tick();
        chk("s4_nrd", nrd[0] - r0, 1);
        chk("s4_nw", nw[0] - b0, 1);
        chk("s4_data", ldata[0][b0], 'hA300);
        chk("s4_addr", laddr[0][b0], 0);
        chk("s4_count", wcount[0], 1);
        chk("s4_ndone", ndone[0], d0 + 1);
        enable = 1'b1;
        for (int i = 0; i < 20 && nw[0] - b0 < 2; i++) tick();
        chk("s4_resume_addr", laddr[0][b0 + 1], 0);
        chk("s4_resume_data", ldata[0][b0 + 1], 'hA301);
        for (int i = 0; i < 6; i++) tick();

        // clear during LAT on the latency-2 instance
        b2 = nw[2];
        push(2, 'hC200);
        for (int i = 0; i < 20 && !rdreq[2]; i++) tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("s5_clr_busy", busy[2], 0);
        chk("s5_clr_addr", addr[2], 7);
        chk("s5_clr_count", wcount[2], 0);
        chk("s5_clr_wdata", wdata[2], 'hC109);
        for (int i = 0; i < 6; i++) tick();
        chk("s5_clr_nw", nw[2] - b2, 0);

        // asynchronous reset while in READ
        b0 = nw[0];
        push(0, 'hA400);
        for (int i = 0; i < 20 && !rdreq[0]; i++) tick();
        chk("s6_in_read", rdreq[0], 1);
        reset = 1'b1;
        #1;
        chk("s6_rst_rdreq", rdreq[0], 0);
        chk("s6_rst_addr", addr[0], 7);
        chk("s6_rst_busy", busy[0], 0);
        chk("s6_rst_wdata", wdata[0], 0);
        chk("s6_rst_count", wcount[0], 0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_rst_nw", nw[0] - b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_to_ram_drain.md
Name: fifo_to_ram_drain

Overview:
Parametrised controller that drains a dual-clock FIFO (read side) into a single-port RAM, one word per transaction, with sequential addressing.
- Handles configurable FIFO read latency (show-ahead or registered output).
- Handles RAM-full stop or wrap-around, session timeout with a done pulse, and an enable/clear interface.
- Sits between the dcfifo read port and the capture RAM in the read clock domain.

Parameters:
DATA_W, 32, data width of FIFO output and RAM write data
ADDR_W, 8, RAM address width; RAM holds 2^ADDR_W words
FIFO_LATENCY, 1, cycles from rdreq_o to valid fifo_data_i; legal 0..3 (0 = show-ahead)
WRAP_EN, 0, 1 = address wraps and draining continues; 0 = stop when RAM full
IDLE_TIMEOUT, 16, consecutive WAIT cycles without a new read before the session ends (>=1)

Ports:
clk_i  in  1  read-domain clock
reset_i  in  1  asynchronous, active-high reset
clear_i  in  1  synchronous restart: abort session, clear full flag
enable_i  in  1  permit starting new word reads
rdempty_i  in  1  FIFO read-side empty
fifo_data_i  in  DATA_W  FIFO q output
rdreq_o  out  1  FIFO read request, one-cycle pulse per word
wren_o  out  1  RAM write enable, one-cycle pulse per word
addr_o  out  ADDR_W  RAM address
wdata_o  out  DATA_W  RAM write data, registered
word_count_o  out  ADDR_W+1  words written this session
ram_full_o  out  1  RAM full, draining halted (WRAP_EN=0 only)
busy_o  out  1  high when state != IDLE
done_o  out  1  one-cycle pulse on session end by timeout

Behaviour:
- Reset values: state IDLE; rdreq_o, wren_o, ram_full_o, busy_o, done_o = 0; addr_o = all ones; wdata_o = 0; word_count_o = 0; latency and timeout counters = 0.
- States are IDLE, READ, LAT, WRITE, WAIT, FULL.
- rdreq_o = 1 only in READ. wren_o = 1 only in WRITE. Both are decoded from state.
- IDLE:
  - If enable_i && !rdempty_i, go to READ, set addr_o <= addr_o+1 (wraps all-ones to 0), and clear word_count_o.
  - Otherwise stay in IDLE.
- READ (1 cycle):
  - If FIFO_LATENCY=0, capture wdata_o <= fifo_data_i and go to WRITE.
  - Otherwise load the latency counter and go to LAT.
- LAT (FIFO_LATENCY cycles): on the final LAT cycle, capture wdata_o <= fifo_data_i and go to WRITE.
- Per-word timing: rdreq_o at cycle n, data sampled at n+FIFO_LATENCY, wren_o at n+FIFO_LATENCY+1. Throughput is one word per FIFO_LATENCY+2 cycles.
- WRITE (1 cycle): addr_o and wdata_o are stable; word_count_o increments at the end of the cycle (modulo 2^(ADDR_W+1)). Next state, in priority order:
  1. If WRAP_EN=0 and addr_o == all ones, go to FULL and set ram_full_o=1.
  2. Else if enable_i && !rdempty_i, go to READ and increment addr_o (modulo 2^ADDR_W).
  3. Else go to WAIT and clear the timeout counter.
- WAIT:
  - If enable_i && !rdempty_i, go to READ and increment addr_o; the timeout counter clears.
  - Else the timeout counter increments. When it reaches IDLE_TIMEOUT, go to IDLE, pulse done_o for 1 cycle, and set addr_o = all ones. word_count_o is held until the next session starts.
- FULL:
  - No rdreq_o is issued; remaining FIFO words are left unread.
  - ram_full_o and word_count_o are held; busy_o=1.
  - The block leaves FULL only via clear_i or reset_i.
- clear_i (priority below reset, above all transitions):
  - Next cycle: state IDLE; addr_o all ones; word_count_o 0; ram_full_o 0; done_o 0; counters 0.
  - A word already requested (READ/LAT) is discarded with no wren_o. wdata_o is held.
- enable_i low: an in-flight word (READ/LAT/WRITE) always completes, then the block enters WAIT. A timeout can occur while disabled.
- rdempty_i is sampled only in IDLE, WRITE and WAIT. rdreq_o is never issued unless rdempty_i was 0 in the deciding cycle.
- reset_i mid-operation: all outputs return to reset values immediately (asynchronously); no partial write completes.

Test Plan:
1. ADDR_W=8, FIFO_LATENCY=1, 4 words preloaded (A0..A3), enable=1 -> rdreq_o every 3 cycles; wren_o at addr 0,1,2,3 with wdata A0..A3; word_count_o=4; done_o pulses after 16 empty WAIT cycles; addr_o=0xFF.
2. FIFO_LATENCY=0 then 2, 6 words -> writes every 2 and 4 cycles respectively; wdata matches the FIFO word issued L cycles after its rdreq, with no off-by-one.
3. ADDR_W=3, WRAP_EN=0, 10 words -> 8 writes at addr 0..7; ram_full_o=1; no rdreq after the 8th; 2 words remain in FIFO. Then clear_i -> ram_full_o=0, next write at addr 0 with the 9th word, word_count_o restarts at 1.
4. ADDR_W=3, WRAP_EN=1, 10 words -> addr sequence 0..7,0,1; word_count_o=10; ram_full_o stays 0.
5. 3 words, then empty for 5 cycles, then 2 words -> no done_o; addresses continue 3,4; done_o fires only after 16 empty cycles; word_count_o=5. With enable_i dropped during LAT -> that word is still written, then no rdreq until enable_i returns.
6. clear_i asserted in LAT, and separately reset_i asserted in READ -> no wren_o for the pending word; all outputs at reset values the following cycle (clear) or immediately (reset).
